// File: rtl/tinyalu_stim_gen.sv
// TinyALU stimulus generator: LFSR-driven weighted-random transactions with corner operands.
// Optional per-opcode transaction counters are enabled by defining TINYALU_STIM_GEN_OPCOUNT_EN.
//
// state    | meaning
// INIT_RST | hold alu_reset_n low for RST_CYC cycles after reset release
// IDLE     | wait for enable
// GEN      | sample LFSR into opcode and operands
// ISSUE    | start high with op/A/B stable until done (or timeout)
// NOP      | one-cycle start pulse with op=000
// RPULSE   | alu_reset_n low for RST_CYC cycles with op=111
// GAP      | start low for one cycle, count the transaction
// FINISH   | run over (count reached or timeout); leaves only on reset
module tinyalu_stim_gen #(
  parameter int          DATA_W  = 8,
  parameter int          NUM_TXN = 1000,
  parameter logic [31:0] SEED    = 32'h1,
  parameter int          RST_CYC = 2,
  parameter int          TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              done,
  output logic              start,
  output logic [2:0]        op,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              alu_reset_n,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [15:0]       txn_count
`ifdef TINYALU_STIM_GEN_OPCOUNT_EN
  ,
  output logic [15:0]       cnt_add,
  output logic [15:0]       cnt_and,
  output logic [15:0]       cnt_xor,
  output logic [15:0]       cnt_mul,
  output logic [15:0]       cnt_nop,
  output logic [15:0]       cnt_rst
`endif
);

  localparam logic [31:0] TAPS     = 32'h80200003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          TMAX     = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int          TW       = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [16:0]   NUM_TXN_W = 17'(NUM_TXN);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [2:0] {INIT_RST, IDLE, GEN, ISSUE, NOP, RPULSE, GAP, FINISH} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                start_q, start_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                arn_q, arn_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                terr_q, terr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          gen_op;
  logic [DATA_W-1:0]   gen_a, gen_b;

  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  // Weighted decode: no_op and rst_op each take two of the eight codes.
  always_comb begin
    gen_op = OP_NOP;
    case (lfsr_q[2:0])
      3'b001:         gen_op = OP_ADD;
      3'b010:         gen_op = OP_AND;
      3'b011:         gen_op = OP_XOR;
      3'b100:         gen_op = OP_MUL;
      3'b110, 3'b111: gen_op = OP_RST;
      default:        gen_op = OP_NOP;
    endcase
    case (lfsr_q[4:3])
      2'b00:   gen_a = '0;
      2'b11:   gen_a = '1;
      default: gen_a = lfsr_q[7 +: DATA_W];
    endcase
    case (lfsr_q[6:5])
      2'b00:   gen_b = '0;
      2'b11:   gen_b = '1;
      default: gen_b = lfsr_q[19 +: DATA_W];
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    start_d = start_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    arn_d   = arn_q;
    fin_d   = fin_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT_RST: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          arn_d   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      IDLE: if (enable && !fin_q) state_d = GEN;
      GEN: begin
        op_d = gen_op;
        a_d  = gen_a;
        b_d  = gen_b;
        case (gen_op)
          OP_NOP: begin
            state_d = NOP;
            start_d = 1'b1;
          end
          OP_RST: begin
            state_d = RPULSE;
            arn_d   = 1'b0;
            timer_d = RST_LOAD;
          end
          default: begin
            state_d = ISSUE;
            start_d = 1'b1;
            timer_d = TO_LOAD;
          end
        endcase
      end
      ISSUE: begin
        if (done) begin
          state_d = GAP;
          start_d = 1'b0;
        end else if (timer_q == '0) begin
          state_d = FINISH;
          start_d = 1'b0;
          terr_d  = 1'b1;
          op_d    = OP_NOP;
          a_d     = '0;
          b_d     = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      NOP: begin
        state_d = GAP;
        start_d = 1'b0;
      end
      RPULSE: begin
        if (timer_q == '0) begin
          state_d = GAP;
          arn_d   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (({1'b0, cnt_q} + 17'd1) == NUM_TXN_W) begin
          state_d = FINISH;
          fin_d   = 1'b1;
          op_d    = OP_NOP;
          a_d     = '0;
          b_d     = '0;
        end else if (enable) begin
          state_d = GEN;
        end else begin
          state_d = IDLE;
        end
      end
      FINISH: state_d = FINISH;
      default: state_d = INIT_RST;
    endcase
    busy_d = (state_d == GEN) || (state_d == ISSUE) || (state_d == NOP) ||
             (state_d == RPULSE) || (state_d == GAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT_RST;
      timer_q <= RST_LOAD;
      lfsr_q  <= SEED_EFF;
      start_q <= 1'b0;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      arn_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      arn_q   <= arn_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TINYALU_STIM_GEN_OPCOUNT_EN
  // op_q still holds the opcode of the transaction being retired in GAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_add <= '0;
      cnt_and <= '0;
      cnt_xor <= '0;
      cnt_mul <= '0;
      cnt_nop <= '0;
      cnt_rst <= '0;
    end else if (state_q == GAP) begin
      case (op_q)
        OP_ADD:  cnt_add <= cnt_add + 16'd1;
        OP_AND:  cnt_and <= cnt_and + 16'd1;
        OP_XOR:  cnt_xor <= cnt_xor + 16'd1;
        OP_MUL:  cnt_mul <= cnt_mul + 16'd1;
        OP_NOP:  cnt_nop <= cnt_nop + 16'd1;
        OP_RST:  cnt_rst <= cnt_rst + 16'd1;
        default: ;
      endcase
    end
  end
`endif

  assign start       = start_q;
  assign op          = op_q;
  assign A           = a_q;
  assign B           = b_q;
  assign alu_reset_n = arn_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
  assign timeout_err = terr_q;
  assign txn_count   = cnt_q;

endmodule

// File: doc/tinyalu_stim_gen.md
# tinyalu_stim_gen

Synthesizable, parametrised TinyALU stimulus generator. An internal LFSR replaces the behavioural random tester loop. The block drives the TinyALU start/op/A/B/reset pins directly, observes `done`, and runs a configurable number of weighted-random transactions. Corner values (all-zeros, all-ones) are injected into the operands. It sits beside the DUT in emulation/FPGA test harnesses, where no simulator-side tester exists.

## Interface
- `DATA_W`, 8: operand width; legal range 4..12.
- `NUM_TXN`, 1000: transactions per run; legal range 1..65535.
- `SEED`, 32'h1: LFSR seed; 0 is replaced by 1.
- `RST_CYC`, 2: cycles `alu_reset_n` is held low for `rst_op` and for the initial reset.
- `TIMEOUT`, 64: maximum cycles to wait for `done`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; level sensitive.
- `done` in 1: TinyALU done.
- `start` out 1: TinyALU start.
- `op` out 3: opcode; no_op=000, add=001, and=010, xor=011, mul=100, rst_op=111.
- `A`, `B` out DATA_W: operands.
- `alu_reset_n` out 1: TinyALU reset, active-low.
- `busy` out 1: a transaction is in flight.
- `finished` out 1: sticky; `NUM_TXN` transactions done.
- `timeout_err` out 1: sticky; `done` was missing.
- `txn_count` out 16: completed transactions.

## Operation
- LFSR: 32-bit Galois, taps 32'h80200003 (x^32+x^22+x^2+x+1); steps every cycle while out of reset.
- FSM states: INIT_RST, IDLE, GEN, ISSUE, NOP, RPULSE, GAP, FINISH.
- INIT_RST: `alu_reset_n`=0 for `RST_CYC` cycles after reset release, then IDLE.
- IDLE: when `enable`=1 and `finished`=0, go to GEN.
- GEN (1 cycle): sample LFSR fields.
  - opcode from lfsr[2:0]: 000/101→no_op, 001→add, 010→and, 011→xor, 100→mul, 110/111→rst_op.
  - A from lfsr[4:3], B from lfsr[6:5]: 00→all-zeros, 11→all-ones, else A=lfsr[7+:DATA_W], B=lfsr[19+:DATA_W].
- Dispatch from GEN: add/and/xor/mul→ISSUE, no_op→NOP, rst_op→RPULSE.
- ISSUE: `start`=1, `op`/`A`/`B` held stable until `done` is sampled 1, then go to GAP.
- NOP: `start`=1 for exactly 1 cycle with op=000, then GAP; `done` is ignored.
- RPULSE: `start`=0, `op`=111, `alu_reset_n`=0 for `RST_CYC` cycles, then GAP.
- GAP: `start`=0 for 1 cycle and `txn_count` increments.
  - Next state: if `txn_count`+1==`NUM_TXN` → FINISH; else if `enable` → GEN; else → IDLE.
- FINISH: `finished`=1, all drive outputs idle; leaves only on `reset`.
- `enable` falling mid-transaction: the current transaction completes and the count is kept. Re-asserting `enable` resumes; the count is not cleared.
- Timeout: in ISSUE, the wait counter reaches `TIMEOUT` with no `done` → `timeout_err`=1, `start`=0, FSM goes to FINISH. `txn_count` does not increment and `finished` stays 0.
- `done` outside ISSUE is ignored.
- `busy`=1 in GEN, ISSUE, NOP, RPULSE and GAP.

## Timing
- Reset values: `start`=0, `op`=0, `A`=0, `B`=0, `alu_reset_n`=0, `busy`=0, `finished`=0, `timeout_err`=0, `txn_count`=0.
- `reset` mid-operation aborts immediately and asynchronously to those values.
- All outputs are registered.
- IDLE→`start` high: 2 cycles (GEN, then ISSUE).
- Minimum transaction period:
  - no_op: 3 cycles (GEN, NOP, GAP).
  - ALU op: 3 cycles plus the `done` latency.
  - rst_op: 2+`RST_CYC` cycles.
- `done` sampled at cycle k of ISSUE → `start` low at k+1, and `txn_count` updates at the end of that GAP cycle.

## Configuration
- `TINYALU_STIM_GEN_OPCOUNT_EN`
- Defined: adds outputs `cnt_add`, `cnt_and`, `cnt_xor`, `cnt_mul`, `cnt_nop`, `cnt_rst` (16 bits each). Each increments in GAP per opcode; all are reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- SEED=1, NUM_TXN=1, ideal ALU model (`done` 1 cycle after `start`), enable=1 → exactly one transaction; `finished`=1 and `txn_count`=1; `start` never re-asserts.
- NUM_TXN=1000, ALU model with random latency 1..3, scoreboard on every `done` → `txn_count`=1000, no `timeout_err`.
  - ALU results match the reference model.
  - A/B distribution: about 25% 0x00 and about 25% 0xFF.
  - Opcode distribution: no_op about 25%, rst_op about 25%.
- `done` tied 0, TIMEOUT=64 → `timeout_err` exactly 64 cycles after `start` rises; `start`=0 the next cycle; `finished`=0.
- `enable` dropped during ISSUE at txn 5 → txn 5 completes; FSM goes to IDLE with `txn_count`=5. Re-enable → resumes at 5 and finishes at NUM_TXN.
- `reset` asserted mid-RPULSE → all outputs at reset values asynchronously.
  - After release: `alu_reset_n` low for exactly RST_CYC=2 cycles, then IDLE.
- OPCOUNT_EN defined, NUM_TXN=200 → sum of all `cnt_*` equals 200.
  - Each counter matches its per-op tally in the bench monitor.
